// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned FETCH_A     = 10;
    localparam int unsigned FETCH_OFS_W = 8;
    localparam int unsigned CYCLE_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Program counter sequencer: IDLE -> RUN -> DONE with jump/branch/stall/halt.
// Optional run-cycle counter output enabled by defining FETCH_CYCLE_CNT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned A     = FETCH_A,
    parameter int unsigned OFS_W = FETCH_OFS_W
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic [A-1:0]            StartAddr,
    input  logic                    Stall,
    input  logic                    JumpEn,
    input  logic [A-1:0]            Target,
    input  logic                    BranchEn,
    input  logic                    Taken,
    input  logic signed [OFS_W-1:0] Offset,
    input  logic                    Halt,
    output logic [A-1:0]            ProgCtr,
    output logic                    Busy,
    output logic                    Done
`ifdef FETCH_CYCLE_CNT_EN
    ,
    output logic [CYCLE_CNT_W-1:0]  CycleCnt
`endif
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [A-1:0] r_pc;
    logic [A-1:0] w_pc_nxt;
    logic [A-1:0] w_ofs_ext;
    logic         w_start_acc;

    // Signed size cast sign-extends; the add then wraps modulo 2^A.
    assign w_ofs_ext = A'(Offset);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_start_acc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_pc_nxt    = StartAddr;
                    w_state_nxt = ST_RUN;
                    w_start_acc = 1'b1;
                end
            end
            ST_RUN: begin
                if (Start) begin
                    w_pc_nxt    = StartAddr;
                    w_start_acc = 1'b1;
                end else if (Halt) begin
                    w_state_nxt = ST_DONE;
                end else if (Stall) begin
                    w_pc_nxt = r_pc;
                end else if (JumpEn) begin
                    w_pc_nxt = Target;
                end else if (BranchEn && Taken) begin
                    w_pc_nxt = r_pc + w_ofs_ext;
                end else begin
                    w_pc_nxt = r_pc + A'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ProgCtr = r_pc;
    assign Busy    = (r_state == ST_RUN);
    assign Done    = (r_state == ST_DONE);

`ifdef FETCH_CYCLE_CNT_EN
    logic [CYCLE_CNT_W-1:0] r_cnt;

    // Counts every cycle spent in RUN, the halting cycle included.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (w_start_acc) begin
            r_cnt <= '0;
        end else if (r_state == ST_RUN && r_cnt != '1) begin
            r_cnt <= r_cnt + CYCLE_CNT_W'(1);
        end
    end

    assign CycleCnt = r_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit (plus cycle counter when
// FETCH_CYCLE_CNT_EN is defined).
module tb_fetch_unit;

    localparam int unsigned A     = 10;
    localparam int unsigned OFS_W = 8;

    logic                    Clk;
    logic                    Reset;
    logic                    Start;
    logic [A-1:0]            StartAddr;
    logic                    Stall;
    logic                    JumpEn;
    logic [A-1:0]            Target;
    logic                    BranchEn;
    logic                    Taken;
    logic signed [OFS_W-1:0] Offset;
    logic                    Halt;
    logic [A-1:0]            ProgCtr;
    logic                    Busy;
    logic                    Done;
`ifdef FETCH_CYCLE_CNT_EN
    logic [15:0]             CycleCnt;
`endif

    fetch_unit #(.A(A), .OFS_W(OFS_W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .StartAddr (StartAddr),
        .Stall     (Stall),
        .JumpEn    (JumpEn),
        .Target    (Target),
        .BranchEn  (BranchEn),
        .Taken     (Taken),
        .Offset    (Offset),
        .Halt      (Halt),
        .ProgCtr   (ProgCtr),
        .Busy      (Busy),
        .Done      (Done)
`ifdef FETCH_CYCLE_CNT_EN
        ,
        .CycleCnt  (CycleCnt)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic                    st;
        logic [A-1:0]            sa;
        logic                    stl;
        logic                    jmp;
        logic [A-1:0]            tgt;
        logic                    br;
        logic                    tk;
        logic signed [OFS_W-1:0] ofs;
        logic                    hlt;
        logic [A-1:0]            pc;
        logic                    busy;
        logic                    done;
    } vec_t;

    int ntests = 0;
    int nfail  = 0;

    function automatic vec_t mkv(int st, int sa, int stl, int jmp, int tgt,
                                 int br, int tk, int ofs, int hlt,
                                 int pc, int b, int d);
        vec_t v;
        v.st   = 1'(st);
        v.sa   = A'(sa);
        v.stl  = 1'(stl);
        v.jmp  = 1'(jmp);
        v.tgt  = A'(tgt);
        v.br   = 1'(br);
        v.tk   = 1'(tk);
        v.ofs  = OFS_W'(ofs);
        v.hlt  = 1'(hlt);
        v.pc   = A'(pc);
        v.busy = 1'(b);
        v.done = 1'(d);
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle_inputs;
        Start = 1'b0; StartAddr = '0; Stall = 1'b0; JumpEn = 1'b0; Target = '0;
        BranchEn = 1'b0; Taken = 1'b0; Offset = '0; Halt = 1'b0;
    endtask

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    vec_t vecs[21];

    initial begin
        //            st  sa   stl jmp tgt  br tk ofs  hlt  pc   b  d
        vecs[0]  = mkv(1, 5,    0, 0, 0,    0, 0, 0,   0,   5,   1, 0);
        vecs[1]  = mkv(0, 0,    0, 0, 0,    0, 0, 0,   0,   6,   1, 0);
        vecs[2]  = mkv(0, 0,    0, 0, 0,    0, 0, 0,   0,   7,   1, 0);
        vecs[3]  = mkv(0, 0,    0, 0, 0,    0, 0, 0,   0,   8,   1, 0);
        vecs[4]  = mkv(0, 0,    0, 1, 20,   0, 0, 0,   0,   20,  1, 0);
        vecs[5]  = mkv(0, 0,    0, 0, 0,    1, 1, -4,  0,   16,  1, 0);
        vecs[6]  = mkv(0, 0,    0, 1, 20,   0, 0, 0,   0,   20,  1, 0);
        vecs[7]  = mkv(0, 0,    0, 0, 0,    1, 0, -4,  0,   21,  1, 0);
        vecs[8]  = mkv(0, 0,    0, 1, 1023, 0, 0, 0,   0,   1023,1, 0);
        vecs[9]  = mkv(0, 0,    0, 0, 0,    0, 0, 0,   0,   0,   1, 0);
        vecs[10] = mkv(0, 0,    0, 1, 40,   0, 0, 0,   0,   40,  1, 0);
        vecs[11] = mkv(0, 0,    0, 1, 100,  1, 1, 3,   0,   100, 1, 0);
        vecs[12] = mkv(0, 0,    0, 1, 40,   0, 0, 0,   0,   40,  1, 0);
        vecs[13] = mkv(0, 0,    1, 1, 100,  0, 0, 0,   0,   40,  1, 0);
        vecs[14] = mkv(0, 0,    0, 0, 0,    1, 1, -50, 0,   1014,1, 0);
        vecs[15] = mkv(1, 7,    0, 0, 0,    0, 0, 0,   1,   7,   1, 0);
        vecs[16] = mkv(0, 0,    0, 1, 50,   0, 0, 0,   0,   50,  1, 0);
        vecs[17] = mkv(0, 0,    0, 0, 0,    0, 0, 0,   1,   50,  0, 1);
        vecs[18] = mkv(1, 9,    0, 0, 0,    0, 0, 0,   0,   50,  0, 0);
        vecs[19] = mkv(0, 0,    0, 0, 0,    0, 0, 0,   0,   50,  0, 0);
        vecs[20] = mkv(0, 0,    0, 1, 200,  0, 0, 0,   0,   50,  0, 0);

        idle_inputs();
        Reset = 1'b1;
        step();
        step();
        check("reset pc",   32'(ProgCtr), 32'd0);
        check("reset busy", 32'(Busy),    32'd0);
        check("reset done", 32'(Done),    32'd0);
        Reset = 1'b0;
        step();
        check("idle pc", 32'(ProgCtr), 32'd0);

        for (int i = 0; i < 21; i++) begin
            Start = vecs[i].st;   StartAddr = vecs[i].sa; Stall = vecs[i].stl;
            JumpEn = vecs[i].jmp; Target = vecs[i].tgt;   BranchEn = vecs[i].br;
            Taken = vecs[i].tk;   Offset = vecs[i].ofs;   Halt = vecs[i].hlt;
            step();
            check($sformatf("v%0d pc", i),   32'(ProgCtr), 32'(vecs[i].pc));
            check($sformatf("v%0d busy", i), 32'(Busy),    32'(vecs[i].busy));
            check($sformatf("v%0d done", i), 32'(Done),    32'(vecs[i].done));
        end
        idle_inputs();

        // Asynchronous reset in the middle of a run.
        Start = 1'b1; StartAddr = A'(300);
        step();
        idle_inputs();
        check("mid pc before reset", 32'(ProgCtr), 32'd300);
        check("mid busy before reset", 32'(Busy), 32'd1);
        #3 Reset = 1'b1;
        #1;
        check("async reset pc",   32'(ProgCtr), 32'd0);
        check("async reset busy", 32'(Busy),    32'd0);
        check("async reset done", 32'(Done),    32'd0);
        step();
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("post reset done c%0d", i), 32'(Done), 32'd0);
            check($sformatf("post reset busy c%0d", i), 32'(Busy), 32'd0);
            check($sformatf("post reset pc c%0d", i), 32'(ProgCtr), 32'd0);
        end

`ifdef FETCH_CYCLE_CNT_EN
        // Ten RUN cycles: 7 advancing, 2 stalled, the last carrying Halt.
        Start = 1'b1; StartAddr = A'(0);
        step();
        Start = 1'b0;
        check("cnt after start", 32'(CycleCnt), 32'd0);
        for (int i = 0; i < 10; i++) begin
            Stall = (i == 3 || i == 4);
            Halt  = (i == 9);
            step();
        end
        idle_inputs();
        check("cnt at done", 32'(CycleCnt), 32'd10);
        check("done with cnt", 32'(Done), 32'd1);
        check("pc at done", 32'(ProgCtr), 32'd7);
        step();
        check("cnt idle hold", 32'(CycleCnt), 32'd10);
        step();
        check("cnt idle hold 2", 32'(CycleCnt), 32'd10);

        Start = 1'b1;
        step();
        Start = 1'b0;
        check("cnt restart clear", 32'(CycleCnt), 32'd0);
        repeat (70000) @(posedge Clk);
        #1;
        check("cnt saturate", 32'(CycleCnt), 32'd65535);
        check("busy long run", 32'(Busy), 32'd1);
        Halt = 1'b1;
        step();
        Halt = 1'b0;
        check("cnt saturate held", 32'(CycleCnt), 32'd65535);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
